// File: rtl/jt51_regwr_pkg.sv
// jt51_regwr_pkg: register address map and strobe-index enum for the JT51 CPU write port.
// Address constants mark either single global registers or the base of a
// slot-register range; strobe_t names the single up_* line a data write drives.
package jt51_regwr_pkg;

    localparam logic [7:0] A_TEST   = 8'h01;
    localparam logic [7:0] A_KEYON  = 8'h08;
    localparam logic [7:0] A_NOISE  = 8'h0F;
    localparam logic [7:0] A_CLKA1  = 8'h10;
    localparam logic [7:0] A_CLKA2  = 8'h11;
    localparam logic [7:0] A_CLKB   = 8'h12;
    localparam logic [7:0] A_TIMER  = 8'h14;
    localparam logic [7:0] A_LFRQ   = 8'h18;
    localparam logic [7:0] A_PMDAMD = 8'h19;
    localparam logic [7:0] A_CTW    = 8'h1B;

    localparam logic [7:0] A_RL     = 8'h20;
    localparam logic [7:0] A_KC     = 8'h28;
    localparam logic [7:0] A_KF     = 8'h30;
    localparam logic [7:0] A_PMS    = 8'h38;
    localparam logic [7:0] A_DT1    = 8'h40;
    localparam logic [7:0] A_TL     = 8'h60;
    localparam logic [7:0] A_KS     = 8'h80;
    localparam logic [7:0] A_AMSEN  = 8'hA0;
    localparam logic [7:0] A_DT2    = 8'hC0;
    localparam logic [7:0] A_D1L    = 8'hE0;

    typedef enum logic [3:0] {
        ST_NONE,
        ST_KEYON,
        ST_RL,
        ST_KC,
        ST_KF,
        ST_PMS,
        ST_DT1,
        ST_TL,
        ST_KS,
        ST_AMSEN,
        ST_DT2,
        ST_D1L
    } strobe_t;

endpackage

// File: rtl/jt51_regwr_dec.sv
// jt51_regwr_dec: combinational address decoder for the JT51 write port.
// Ports: addr (latched register address) -> sel (strobe index, ST_NONE if not a
// slot register), is_global (address is a directly stored global register),
// op/ch (target operator and channel).
// Config: JT51_REGWR_TEST_EN makes address 0x01 a global register.
module jt51_regwr_dec
    import jt51_regwr_pkg::*;
(
    input  logic [7:0] addr,
    output strobe_t    sel,
    output logic       is_global,
    output logic [1:0] op,
    output logic [2:0] ch
);

    always_comb begin
        sel = addr == A_KEYON ? ST_KEYON :
              addr >= A_D1L   ? ST_D1L   :
              addr >= A_DT2   ? ST_DT2   :
              addr >= A_AMSEN ? ST_AMSEN :
              addr >= A_KS    ? ST_KS    :
              addr >= A_TL    ? ST_TL    :
              addr >= A_DT1   ? ST_DT1   :
              addr >= A_PMS   ? ST_PMS   :
              addr >= A_KF    ? ST_KF    :
              addr >= A_KC    ? ST_KC    :
              addr >= A_RL    ? ST_RL    : ST_NONE;
    end

    // Channel registers (0x20-0x3F) carry no operator field.
    assign op = (addr >= A_RL && addr < A_DT1) ? 2'd0 : addr[4:3];
    assign ch = addr[2:0];

`ifdef JT51_REGWR_TEST_EN
    assign is_global = addr inside {A_TEST, A_NOISE, A_CLKA1, A_CLKA2, A_CLKB,
                                    A_TIMER, A_LFRQ, A_PMDAMD, A_CTW};
`else
    assign is_global = addr inside {A_NOISE, A_CLKA1, A_CLKA2, A_CLKB,
                                    A_TIMER, A_LFRQ, A_PMDAMD, A_CTW};
`endif

endmodule

// File: rtl/jt51_regwr.sv
// jt51_regwr: CPU-side write port of the JT51 register path.
// Ports: clk/rst (async, active-high), cen (slot clock enable), cs_n/wr_n/a0/din
// (YM2151 bus); busy/dout/op/ch/up_* drive the slot-serialised register file for
// one 32-slot round; value_A..lfo_rst are the global registers held as levels.
// Config: JT51_REGWR_TEST_EN enables the 0x01 test register (lfo_rst), else lfo_rst=0.
module jt51_regwr
    import jt51_regwr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] din,
    output logic       busy,
    output logic [7:0] dout,
    output logic [1:0] op,
    output logic [2:0] ch,
    output logic       up_rl,
    output logic       up_kc,
    output logic       up_kf,
    output logic       up_pms,
    output logic       up_dt1,
    output logic       up_tl,
    output logic       up_ks,
    output logic       up_amsen,
    output logic       up_dt2,
    output logic       up_d1l,
    output logic       up_keyon,
    output logic [9:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       en_irq_A,
    output logic       en_irq_B,
    output logic       clr_flag_A,
    output logic       clr_flag_B,
    output logic       csm,
    output logic [7:0] lfo_freq,
    output logic [6:0] lfo_amd,
    output logic [6:0] lfo_pmd,
    output logic [1:0] lfo_w,
    output logic [1:0] ct,
    output logic       noise_en,
    output logic [4:0] nfrq,
    output logic       lfo_rst
);

    logic [7:0] addr;
    logic       wr_l;
    logic       wr_ev;
    logic [4:0] cnt;
    strobe_t    sel;
    strobe_t    sel_q;
    logic       is_global;
    logic [1:0] dec_op;
    logic [2:0] dec_ch;

    jt51_regwr_dec u_dec (
        .addr      (addr),
        .sel       (sel),
        .is_global (is_global),
        .op        (dec_op),
        .ch        (dec_ch)
    );

    // wr_l remembers wr_n from the previous clk, so a long low pulse is one write.
    assign wr_ev = !cs_n && !wr_n && wr_l;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_l       <= 1'b1;
            addr       <= 8'd0;
            cnt        <= 5'd0;
            busy       <= 1'b0;
            sel_q      <= ST_NONE;
            dout       <= 8'd0;
            op         <= 2'd0;
            ch         <= 3'd0;
            value_A    <= 10'd0;
            value_B    <= 8'd0;
            load_A     <= 1'b0;
            load_B     <= 1'b0;
            en_irq_A   <= 1'b0;
            en_irq_B   <= 1'b0;
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
            csm        <= 1'b0;
            lfo_freq   <= 8'd0;
            lfo_amd    <= 7'd0;
            lfo_pmd    <= 7'd0;
            lfo_w      <= 2'd0;
            ct         <= 2'd0;
            noise_en   <= 1'b0;
            nfrq       <= 5'd0;
`ifdef JT51_REGWR_TEST_EN
            lfo_rst    <= 1'b0;
`endif
        end else begin
            wr_l       <= wr_n;
            clr_flag_A <= 1'b0;
            clr_flag_B <= 1'b0;
            // The round ends on the 32nd cen pulse.
            if (busy && cen) begin
                cnt <= cnt + 5'd1;
                if (cnt == 5'd31)
                    busy <= 1'b0;
            end
            if (wr_ev && !a0)
                addr <= din;
            // A new slot-register write restarts the round, overriding the counter update above.
            if (wr_ev && a0 && sel != ST_NONE) begin
                sel_q <= sel;
                op    <= dec_op;
                ch    <= dec_ch;
                dout  <= din;
                busy  <= 1'b1;
                cnt   <= 5'd0;
            end
            if (wr_ev && a0 && is_global) begin
                case (addr)
                    A_NOISE: begin
                        noise_en <= din[7];
                        nfrq     <= din[4:0];
                    end
                    A_CLKA1: value_A[9:2] <= din;
                    A_CLKA2: value_A[1:0] <= din[1:0];
                    A_CLKB:  value_B <= din;
                    A_TIMER: begin
                        csm        <= din[7];
                        clr_flag_B <= din[5];
                        clr_flag_A <= din[4];
                        en_irq_B   <= din[3];
                        en_irq_A   <= din[2];
                        load_B     <= din[1];
                        load_A     <= din[0];
                    end
                    A_LFRQ:  lfo_freq <= din;
                    A_PMDAMD: begin
                        if (din[7])
                            lfo_pmd <= din[6:0];
                        else
                            lfo_amd <= din[6:0];
                    end
                    A_CTW: begin
                        ct    <= din[7:6];
                        lfo_w <= din[1:0];
                    end
`ifdef JT51_REGWR_TEST_EN
                    A_TEST:  lfo_rst <= din[1];
`endif
                    default: ;
                endcase
            end
        end
    end

`ifndef JT51_REGWR_TEST_EN
    assign lfo_rst = 1'b0;
`endif

    assign up_keyon = busy && sel_q == ST_KEYON;
    assign up_rl    = busy && sel_q == ST_RL;
    assign up_kc    = busy && sel_q == ST_KC;
    assign up_kf    = busy && sel_q == ST_KF;
    assign up_pms   = busy && sel_q == ST_PMS;
    assign up_dt1   = busy && sel_q == ST_DT1;
    assign up_tl    = busy && sel_q == ST_TL;
    assign up_ks    = busy && sel_q == ST_KS;
    assign up_amsen = busy && sel_q == ST_AMSEN;
    assign up_dt2   = busy && sel_q == ST_DT2;
    assign up_d1l   = busy && sel_q == ST_D1L;

endmodule

// File: tb/tb_jt51_regwr.sv
// tb_jt51_regwr: scoreboard bench for jt51_regwr; stimulus queues timed expectations, a negedge monitor checks them.
module tb_jt51_regwr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b1;
    logic       cs_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       a0 = 1'b0;
    logic [7:0] din = 8'd0;
    logic       busy;
    logic [7:0] dout;
    logic [1:0] op;
    logic [2:0] ch;
    logic       up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl, up_ks, up_amsen, up_dt2, up_d1l, up_keyon;
    logic [9:0] value_A;
    logic [7:0] value_B;
    logic       load_A, load_B, en_irq_A, en_irq_B, clr_flag_A, clr_flag_B, csm;
    logic [7:0] lfo_freq;
    logic [6:0] lfo_amd, lfo_pmd;
    logic [1:0] lfo_w, ct;
    logic       noise_en;
    logic [4:0] nfrq;
    logic       lfo_rst;

`ifdef JT51_REGWR_TEST_EN
    localparam logic [15:0] LFORST_EXP = 16'd1;
`else
    localparam logic [15:0] LFORST_EXP = 16'd0;
`endif

    jt51_regwr dut (
        .clk(clk), .rst(rst), .cen(cen), .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .din(din),
        .busy(busy), .dout(dout), .op(op), .ch(ch),
        .up_rl(up_rl), .up_kc(up_kc), .up_kf(up_kf), .up_pms(up_pms),
        .up_dt1(up_dt1), .up_tl(up_tl), .up_ks(up_ks), .up_amsen(up_amsen),
        .up_dt2(up_dt2), .up_d1l(up_d1l), .up_keyon(up_keyon),
        .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
        .en_irq_A(en_irq_A), .en_irq_B(en_irq_B), .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
        .csm(csm), .lfo_freq(lfo_freq), .lfo_amd(lfo_amd), .lfo_pmd(lfo_pmd),
        .lfo_w(lfo_w), .ct(ct), .noise_en(noise_en), .nfrq(nfrq), .lfo_rst(lfo_rst)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum {F_BUSY, F_UP, F_OP, F_CH, F_DOUT, F_TMR, F_VA, F_VB, F_LFRQ,
                  F_AMD, F_PMD, F_LFOW, F_CT, F_NOISE, F_LFORST} fid_t;
    typedef struct {
        int          cyc;
        fid_t        f;
        logic [15:0] v;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // UP bits: keyon=400 rl=200 kc=100 kf=080 pms=040 dt1=020 tl=010 ks=008 amsen=004 dt2=002 d1l=001
    // TMR bits: {csm, clr_B, clr_A, en_irq_B, en_irq_A, load_B, load_A}
    function automatic logic [15:0] field(input fid_t f);
        case (f)
            F_BUSY:  return {15'd0, busy};
            F_UP:    return {5'd0, up_keyon, up_rl, up_kc, up_kf, up_pms, up_dt1,
                             up_tl, up_ks, up_amsen, up_dt2, up_d1l};
            F_OP:    return {14'd0, op};
            F_CH:    return {13'd0, ch};
            F_DOUT:  return {8'd0, dout};
            F_TMR:   return {9'd0, csm, clr_flag_B, clr_flag_A, en_irq_B, en_irq_A, load_B, load_A};
            F_VA:    return {6'd0, value_A};
            F_VB:    return {8'd0, value_B};
            F_LFRQ:  return {8'd0, lfo_freq};
            F_AMD:   return {9'd0, lfo_amd};
            F_PMD:   return {9'd0, lfo_pmd};
            F_LFOW:  return {14'd0, lfo_w};
            F_CT:    return {14'd0, ct};
            F_NOISE: return {10'd0, noise_en, nfrq};
            default: return {15'd0, lfo_rst};
        endcase
    endfunction

    always @(negedge clk) begin : mon
        exp_t        keep[$];
        logic [15:0] got;
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc) begin
                got = field(sb[i].f);
                n_vec++;
                if (got !== sb[i].v) begin
                    n_err++;
                    $display("FAIL %s @cyc %0d: got %h expected %h", sb[i].name, cyc, got, sb[i].v);
                end
            end else if (sb[i].cyc < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL %s @cyc %0d: never sampled", sb[i].name, sb[i].cyc);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    task automatic exp_at(input int c, input fid_t f, input logic [15:0] v, input string n);
        exp_t e;
        e.cyc = c; e.f = f; e.v = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic exp_zero(input int c, input string n);
        for (int k = 0; k <= int'(F_LFORST); k++)
            exp_at(c, fid_t'(k), 16'd0, n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle clock, then wr_n low for the write edge (cyc+2 at call) plus hold extra clocks.
    task automatic wr(input logic a, input logic [7:0] d, input int hold);
        tick();
        cs_n = 1'b0; wr_n = 1'b0; a0 = a; din = d;
        tick();
        repeat (hold) tick();
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    int w, w2;

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        exp_zero(cyc, "reset");
        tick();

        // keyon round, long wr_n pulse must count once
        wr(1'b0, 8'h08, 0);
        w = cyc + 2;
        exp_at(w, F_BUSY, 16'h1, "keyon_busy");
        exp_at(w, F_UP, 16'h400, "keyon_up");
        exp_at(w, F_DOUT, 16'h7B, "keyon_dout");
        exp_at(w + 31, F_BUSY, 16'h1, "keyon_busy_31");
        exp_at(w + 31, F_UP, 16'h400, "keyon_up_31");
        exp_at(w + 32, F_BUSY, 16'h0, "keyon_busy_end");
        exp_at(w + 32, F_UP, 16'h0, "keyon_up_end");
        exp_at(w + 32, F_DOUT, 16'h7B, "keyon_dout_end");
        wr(1'b1, 8'h7B, 3);
        wait_to(w + 34);

        // dt1 round with a global write in the middle
        wr(1'b0, 8'h5D, 0);
        w = cyc + 2;
        exp_at(w, F_UP, 16'h020, "dt1_up");
        exp_at(w, F_OP, 16'h3, "dt1_op");
        exp_at(w, F_CH, 16'h5, "dt1_ch");
        exp_at(w, F_DOUT, 16'h31, "dt1_dout");
        exp_at(w + 31, F_BUSY, 16'h1, "dt1_busy_31");
        exp_at(w + 32, F_BUSY, 16'h0, "dt1_busy_end");
        wr(1'b1, 8'h31, 0);
        wr(1'b0, 8'h12, 0);
        exp_at(w + 4, F_VB, 16'hA5, "vb_during_busy");
        exp_at(w + 4, F_UP, 16'h020, "dt1_up_kept");
        exp_at(w + 4, F_DOUT, 16'h31, "dt1_dout_kept");
        wr(1'b1, 8'hA5, 0);
        wait_to(w + 34);

        // timer control: clear pulses last one cycle, no round
        wr(1'b0, 8'h14, 0);
        w = cyc + 2;
        exp_at(w, F_TMR, 16'h75, "timer_ctl");
        exp_at(w, F_BUSY, 16'h0, "timer_busy");
        exp_at(w + 1, F_TMR, 16'h45, "timer_ctl_after");
        wr(1'b1, 8'hB5, 0);
        repeat (3) tick();

        // kc round aborted by kf write; kf round stretched by a cen gap
        wr(1'b0, 8'h28, 0);
        w = cyc + 2;
        exp_at(w, F_UP, 16'h100, "kc_up");
        exp_at(w, F_OP, 16'h0, "kc_op");
        exp_at(w, F_CH, 16'h0, "kc_ch");
        exp_at(w, F_DOUT, 16'h4A, "kc_dout");
        wr(1'b1, 8'h4A, 0);
        repeat (4) tick();
        wr(1'b0, 8'h30, 0);
        w2 = cyc + 2;
        exp_at(w2 - 1, F_UP, 16'h100, "kc_up_late");
        exp_at(w2 - 1, F_BUSY, 16'h1, "kc_busy_late");
        exp_at(w2, F_UP, 16'h080, "kf_up");
        exp_at(w2, F_OP, 16'h0, "kf_op");
        exp_at(w2, F_CH, 16'h0, "kf_ch");
        exp_at(w2, F_DOUT, 16'h12, "kf_dout");
        exp_at(w2 + 37, F_BUSY, 16'h1, "kf_busy_37");
        exp_at(w2 + 37, F_UP, 16'h080, "kf_up_37");
        exp_at(w2 + 38, F_BUSY, 16'h0, "kf_busy_end");
        exp_at(w2 + 38, F_UP, 16'h0, "kf_up_end");
        wr(1'b1, 8'h12, 0);
        repeat (5) tick();
        cen = 1'b0;
        repeat (6) tick();
        cen = 1'b1;
        wait_to(w2 + 40);

        // LFO depth: d7 selects PMD vs AMD
        wr(1'b0, 8'h19, 0);
        w = cyc + 2;
        exp_at(w, F_PMD, 16'h05, "pmd");
        exp_at(w, F_AMD, 16'h00, "amd_untouched");
        wr(1'b1, 8'h85, 0);
        w = cyc + 2;
        exp_at(w, F_AMD, 16'h05, "amd");
        exp_at(w, F_PMD, 16'h05, "pmd_kept");
        exp_at(w, F_BUSY, 16'h0, "lfo_busy");
        wr(1'b1, 8'h05, 0);

        // remaining global registers
        wr(1'b0, 8'h18, 0);
        exp_at(cyc + 2, F_LFRQ, 16'h9C, "lfo_freq");
        wr(1'b1, 8'h9C, 0);
        wr(1'b0, 8'h1B, 0);
        exp_at(cyc + 2, F_CT, 16'h3, "ct");
        exp_at(cyc + 2, F_LFOW, 16'h2, "lfo_w");
        wr(1'b1, 8'hC2, 0);
        wr(1'b0, 8'h0F, 0);
        exp_at(cyc + 2, F_NOISE, 16'h3A, "noise");
        wr(1'b1, 8'h9A, 0);
        wr(1'b0, 8'h10, 0);
        exp_at(cyc + 2, F_VA, 16'h2AC, "value_A_hi");
        wr(1'b1, 8'hAB, 0);
        wr(1'b0, 8'h11, 0);
        exp_at(cyc + 2, F_VA, 16'h2AF, "value_A_lo");
        wr(1'b1, 8'h03, 0);

        // unmapped address is ignored
        wr(1'b0, 8'h02, 0);
        w = cyc + 2;
        exp_at(w, F_BUSY, 16'h0, "ignored_busy");
        exp_at(w, F_UP, 16'h0, "ignored_up");
        exp_at(w + 1, F_LFRQ, 16'h9C, "ignored_lfrq");
        exp_at(w + 1, F_VA, 16'h2AF, "ignored_va");
        wr(1'b1, 8'hFF, 0);

        // test register
        wr(1'b0, 8'h01, 0);
        w = cyc + 2;
        exp_at(w, F_LFORST, LFORST_EXP, "lfo_rst");
        exp_at(w, F_BUSY, 16'h0, "test_busy");
        wr(1'b1, 8'h02, 0);

        // d1l round interrupted by reset
        wr(1'b0, 8'hFB, 0);
        w = cyc + 2;
        exp_at(w, F_UP, 16'h001, "d1l_up");
        exp_at(w, F_OP, 16'h3, "d1l_op");
        exp_at(w, F_CH, 16'h3, "d1l_ch");
        exp_at(w, F_DOUT, 16'h55, "d1l_dout");
        exp_at(w, F_BUSY, 16'h1, "d1l_busy");
        wr(1'b1, 8'h55, 0);
        repeat (5) tick();
        exp_zero(cyc, "midreset");
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_at(cyc, F_BUSY, 16'h0, "post_reset_busy");
        exp_at(cyc + 1, F_BUSY, 16'h0, "post_reset_busy_1");
        exp_at(cyc + 1, F_UP, 16'h0, "post_reset_up");
        repeat (3) tick();

        for (int g = 0; g < 200 && sb.size() > 0; g++) tick();
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations pending, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jt51_regwr.md
# jt51_regwr

CPU-side write port of the JT51 register path. It accepts YM2151-style bus writes: an address latch write followed by a data write. It decodes the latched address and then drives the per-slot update strobes (`up_*`), together with the target `op`/`ch` and the data byte, into the slot-serialised register file. The strobes are held for one full 32-slot round, so every pipeline stage in the register file matches the target once. Global registers (timers, CSM, LFO, noise) are stored here and exported as levels.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- cen  in  1  P1 clock enable; same enable as the register file's slot counter
- cs_n  in  1  chip select, active-low
- wr_n  in  1  write strobe, active-low; sampled on clk
- a0  in  1  0 = address write, 1 = data write
- din  in  8  CPU data
- busy  out  1  write round in progress
- dout  out  8  held data byte for the register file
- op  out  2  target operator, addr[4:3]
- ch  out  3  target channel, addr[2:0]
- up_rl, up_kc, up_kf, up_pms  out  1 each  channel-register update strobes
- up_dt1, up_tl, up_ks, up_amsen, up_dt2, up_d1l  out  1 each  operator-register update strobes
- up_keyon  out  1  key-on register strobe
- value_A  out  10  timer A value
- value_B  out  8  timer B value
- load_A, load_B  out  1 each  timer run enables
- en_irq_A, en_irq_B  out  1 each  IRQ enables
- clr_flag_A, clr_flag_B  out  1 each  one-clk flag-clear pulses
- csm  out  1  CSM mode
- lfo_freq  out  8  LFO frequency
- lfo_amd  out  7  AM depth
- lfo_pmd  out  7  PM depth
- lfo_w  out  2  LFO waveform
- ct  out  2  CT outputs
- noise_en  out  1  noise enable
- nfrq  out  5  noise frequency
- lfo_rst  out  1  LFO reset (test register)

## Operation
- A write occurs on a clk edge where `cs_n=0` and `wr_n=0`. The edge is detected on the falling edge of `wr_n`, so a long low pulse counts as one write.
- Address write (`a0=0`): latch `addr<=din`. Nothing else changes.
- Data write (`a0=1`), decoded from `addr`:
  - 0x08: up_keyon.
  - 0x20-0x27: up_rl. 0x28-0x2F: up_kc. 0x30-0x37: up_kf. 0x38-0x3F: up_pms.
  - 0x40-0x5F: up_dt1. 0x60-0x7F: up_tl. 0x80-0x9F: up_ks. 0xA0-0xBF: up_amsen. 0xC0-0xDF: up_dt2. 0xE0-0xFF: up_d1l.
  - For all of the above: `op<=addr[4:3]` (0 for the 0x20-0x3F range), `ch<=addr[2:0]`, `dout<=din`, `busy<=1`, round counter `<=0`.
  - Global registers are written immediately, with no busy round:
    - 0x0F: noise_en = d7, nfrq = d[4:0].
    - 0x10: value_A[9:2]. 0x11: value_A[1:0] = d[1:0].
    - 0x12: value_B.
    - 0x14: csm = d7, clr_flag_B = d5 (pulse), clr_flag_A = d4 (pulse), en_irq_B/A = d3/d2, load_B/A = d1/d0.
    - 0x18: lfo_freq.
    - 0x19: d7=1 writes lfo_pmd, else lfo_amd; value is d[6:0].
    - 0x1B: ct = d[7:6], lfo_w = d[1:0].
    - Any other address: ignored.
- Exactly one `up_*` is high while `busy=1`. All `up_*` are 0 when idle.
- Round counter: 5 bits, increments on `cen` while busy. When it reaches 31 with `cen` high, busy and all `up_*` clear on that edge.
- A data write during busy aborts the current round and starts a new one; the new target and data take effect immediately. A global-register write during busy does not disturb the round.
- Address write during busy: allowed; it affects only the next data write.

## Timing
- Write at clk edge N: `busy`, `up_*`, `op`, `ch` and `dout` are valid from edge N+1.
- Hold: exactly 32 `cen` pulses; busy deasserts at the edge of the 32nd pulse.
- Global registers update at N+1. `clr_flag_*` is high for the single clk cycle N+1 only.
- Reset values: all outputs 0; `addr=0`; counter 0; `wr_n` edge detector armed.
- Reset mid-round drops the round immediately; there is no resumption.

## Configuration
- `JT51_REGWR_TEST_EN` defined: address 0x01 is decoded, and `lfo_rst<=d1`.
- Not defined: 0x01 writes are ignored and `lfo_rst` is tied to 0.

## Structure
- Package `jt51_regwr_pkg`: address-range constants (KEYON 0x08, RL 0x20, KC 0x28, KF 0x30, PMS 0x38, DT1 0x40, TL 0x60, KS 0x80, AMSEN 0xA0, DT2 0xC0, D1L 0xE0, and the global addresses) and a strobe-index enum.
- Sub-module `jt51_regwr_dec`: purely combinational `addr`->{strobe index, is_global, op, ch} decoder. The top level holds the edge detector, the round counter and the global registers.

## Test plan
- Address write 0x08, then data 0x7B: `up_keyon=1`, `dout=0x7B`, `busy` high for 32 cen, then all strobes 0.
- Address write 0x5D, then data 0x31: `up_dt1=1`, `op=3`, `ch=5`, `dout=0x31`.
- Address write 0x14, then data 0xB5: `csm=1`, `clr_flag_B=1` for one clk, `en_irq_A=1`, `load_A=1`, `busy` stays 0.
- Write 0x28/0x4A, then 0x30/0x12 after 10 cen: `up_kc` drops, `up_kf=1`, counter restarts, busy lasts 32 further cen.
- Address write 0x19, data 0x85, then data 0x05: `lfo_pmd=5`, `lfo_amd=5`.
- Address write 0x01, data 0x02: `lfo_rst=1` with `JT51_REGWR_TEST_EN` defined, 0 without. Also assert `rst` mid-round and check all outputs return to 0.
